// File: rtl/syn_ex_muldiv.sv
// EX-stage iterative multiply/divide unit with HI/LO, MF/MT moves, stall
// generation and a parameterised syscall path (display latch, sticky halt).
module syn_ex_muldiv #(
   parameter int DATA_W   = 32,
   parameter int SYS_HALT = 10,
   parameter int SYS_DISP = 34
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [3:0]        md_op,
   input  logic [DATA_W-1:0] data_x,
   input  logic [DATA_W-1:0] data_y,
   input  logic              syscall_en,
   input  logic [DATA_W-1:0] data_v0,
   input  logic [DATA_W-1:0] data_a0,
   output logic [DATA_W-1:0] md_res,
   output logic              stall,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] display,
   output logic              halt
);

   localparam int CW = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] L_HALT = DATA_W'(SYS_HALT);
   localparam logic [DATA_W-1:0] L_DISP = DATA_W'(SYS_DISP);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t r_state, w_state_next;

   logic [DATA_W-1:0] r_hi, r_lo, r_acc, r_q, r_m, r_display;
   logic [CW-1:0]     r_cnt;
   logic              r_done, r_halt, r_is_div, r_neg_lo, r_neg_hi, r_dz;

   logic              w_busy, w_last, w_start, w_md_op, w_is_div, w_signed;
   logic              w_x_neg, w_y_neg, w_ge;
   logic [DATA_W-1:0] w_x_mag, w_y_mag, w_acc_nx, w_q_nx, w_hi_fin, w_lo_fin;
   logic [DATA_W:0]   w_sum, w_shift, w_diff;
   logic [2*DATA_W-1:0] w_prod;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_next = S_RUN;
         S_RUN:   if (r_cnt == '0) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      w_busy = (r_state == S_RUN);
      w_last = w_busy && (r_cnt == '0);
   end

   assign w_md_op  = (md_op >= OP_MULT) && (md_op <= OP_MTLO);
   assign w_start  = en && !w_busy && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
   assign w_is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
   assign w_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
   assign w_x_neg  = w_signed && data_x[DATA_W-1];
   assign w_y_neg  = w_signed && data_y[DATA_W-1];
   assign w_x_mag  = w_x_neg ? -data_x : data_x;
   assign w_y_mag  = w_y_neg ? -data_y : data_y;

   // One iteration: shift-add for multiply ({acc,q} shifts right),
   // restoring shift-subtract for divide ({acc,q} shifts left).
   assign w_sum   = {1'b0, r_acc} + {1'b0, r_m};
   assign w_shift = {r_acc, r_q[DATA_W-1]};
   assign w_diff  = w_shift - {1'b0, r_m};
   assign w_ge    = ~w_diff[DATA_W];

   always_comb begin
      if (r_is_div) begin
         w_acc_nx = w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
         w_q_nx   = {r_q[DATA_W-2:0], w_ge};
      end else if (r_q[0]) begin
         w_acc_nx = w_sum[DATA_W:1];
         w_q_nx   = {w_sum[0], r_q[DATA_W-1:1]};
      end else begin
         w_acc_nx = {1'b0, r_acc[DATA_W-1:1]};
         w_q_nx   = {r_acc[0], r_q[DATA_W-1:1]};
      end
   end

   // Sign correction of the final step; divide-by-zero forces an all-ones quotient
   // while the remainder path naturally reproduces the dividend.
   always_comb begin
      w_prod = {w_acc_nx, w_q_nx};
      if (r_neg_lo) w_prod = -w_prod;
      if (r_is_div) begin
         w_lo_fin = r_dz ? '1 : (r_neg_lo ? -w_q_nx : w_q_nx);
         w_hi_fin = r_neg_hi ? -w_acc_nx : w_acc_nx;
      end else begin
         w_lo_fin = w_prod[DATA_W-1:0];
         w_hi_fin = w_prod[2*DATA_W-1:DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_acc     <= '0;
         r_q       <= '0;
         r_m       <= '0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_display <= '0;
         r_halt    <= 1'b0;
         r_is_div  <= 1'b0;
         r_neg_lo  <= 1'b0;
         r_neg_hi  <= 1'b0;
         r_dz      <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_start) begin
            r_acc    <= '0;
            r_q      <= w_is_div ? w_x_mag : w_y_mag;
            r_m      <= w_is_div ? w_y_mag : w_x_mag;
            r_cnt    <= CW'(DATA_W - 1);
            r_is_div <= w_is_div;
            r_neg_lo <= w_x_neg ^ w_y_neg;
            r_neg_hi <= w_x_neg;
            r_dz     <= w_is_div && (data_y == '0);
         end else if (w_busy) begin
            r_acc <= w_acc_nx;
            r_q   <= w_q_nx;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
               r_hi <= w_hi_fin;
               r_lo <= w_lo_fin;
            end
         end
         if (en && !w_busy && (md_op == OP_MTHI)) r_hi <= data_x;
         if (en && !w_busy && (md_op == OP_MTLO)) r_lo <= data_x;
         if (en && syscall_en) begin
            if (data_v0 == L_DISP) r_display <= data_a0;
            if (data_v0 == L_HALT) r_halt    <= 1'b1;
         end
      end
   end

   always_comb begin
      md_res = '0;
      if (!w_busy && (md_op == OP_MFHI)) md_res = r_hi;
      if (!w_busy && (md_op == OP_MFLO)) md_res = r_lo;
   end

   assign stall   = w_busy && w_md_op && en;
   assign busy    = w_busy;
   assign done    = r_done;
   assign display = r_display;
   assign halt    = r_halt;

endmodule

// File: tb/tb_syn_ex_muldiv.sv
// Scoreboarded bench for syn_ex_muldiv: expected MFHI/MFLO data is queued by
// the driver and checked by a monitor whenever a read is presented.
module tb_syn_ex_muldiv;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n, en, syscall_en;
   logic [3:0]    md_op;
   logic [W-1:0]  data_x, data_y, data_v0, data_a0;
   logic [W-1:0]  md_res, display;
   logic          stall, busy, done, halt;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   syn_ex_muldiv #(.DATA_W(W), .SYS_HALT(10), .SYS_DISP(34)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .md_op(md_op),
      .data_x(data_x), .data_y(data_y), .syscall_en(syscall_en),
      .data_v0(data_v0), .data_a0(data_a0), .md_res(md_res),
      .stall(stall), .busy(busy), .done(done), .display(display), .halt(halt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else
         $display("ok   %s: 0x%08h", name, act);
   endtask

   // Monitor: any unstalled MFHI/MFLO presents an output to score
   always @(negedge clk) begin
      if (rst_n && en && !busy && (md_op == 4'd5 || md_op == 4'd6)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mf_read: got 0x%08h with no expected entry", md_res);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (md_res !== e) begin
               errors++;
               $display("FAIL mf_read op%0d: got 0x%08h expected 0x%08h", md_op, md_res, e);
            end else
               $display("ok   mf_read op%0d: 0x%08h", md_op, md_res);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [3:0] op, input logic [W-1:0] exp);
      exp_q.push_back(exp);
      en = 1'b1; md_op = op;
      step();
      md_op = 4'd0;
   endtask

   task automatic run_md(input string name, input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int cyc;
      en = 1'b1; md_op = op; data_x = x; data_y = y;
      step();
      md_op = 4'd0;
      chk({name, "_busy_start"}, {31'd0, busy}, 1);
      cyc = 0;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (done) begin cyc = i; break; end
      end
      chk({name, "_latency"}, cyc, 32);
      chk({name, "_busy_end"}, {31'd0, busy}, 0);
      rd(4'd6, elo);
      chk({name, "_done_pulse"}, {31'd0, done}, 0);
      rd(4'd5, ehi);
   endtask

   initial begin
      int n, bad;
      rst_n = 1'b0; en = 1'b0; md_op = 4'd0; syscall_en = 1'b0;
      data_x = '0; data_y = '0; data_v0 = '0; data_a0 = '0;
      step(); step();
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_halt", {31'd0, halt}, 0);
      chk("rst_display", display, 0);
      rst_n = 1'b1;
      step();
      rd(4'd5, 32'h0);
      rd(4'd6, 32'h0);

      run_md("mult",  4'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run_md("multu", 4'd2, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1);
      run_md("divu",  4'd4, 32'd100, 32'd7, 32'd2, 32'd14);
      run_md("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_md("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
      run_md("divu_z", 4'd4, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);
      run_md("div_z",  4'd3, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF);

      // MFLO held behind a running MULT 7*6
      en = 1'b1; md_op = 4'd1; data_x = 32'd7; data_y = 32'd6;
      step();
      md_op = 4'd0; syscall_en = 1'b1; data_v0 = 32'd5;
      #1;
      chk("nonmd_nostall", {31'd0, stall}, 0);
      step();
      syscall_en = 1'b0;
      exp_q.push_back(32'd42);
      md_op = 4'd6;
      #1;
      n = 0; bad = 0;
      while (stall && n < 100) begin
         if (md_res !== '0) bad++;
         n++;
         step();
      end
      chk("stall_cycles", n, 31);
      chk("stall_mdres_zero", bad, 0);
      chk("stall_release_done", {31'd0, done}, 1);
      step();
      md_op = 4'd0;
      rd(4'd5, 32'h0);

      // Syscalls
      syscall_en = 1'b1; data_v0 = 32'd34; data_a0 = 32'hCAFE; en = 1'b1;
      step();
      chk("disp_cafe", display, 32'hCAFE);
      data_v0 = 32'd10;
      step();
      chk("halt_set", {31'd0, halt}, 1);
      data_v0 = 32'd34; data_a0 = 32'h1234; en = 1'b0;
      step();
      chk("disp_en0", display, 32'hCAFE);
      data_v0 = 32'd7; en = 1'b1;
      step();
      chk("disp_other", display, 32'hCAFE);
      data_v0 = 32'd34; data_a0 = 32'hBEEF;
      step();
      chk("disp_after_halt", display, 32'hBEEF);
      chk("halt_sticky", {31'd0, halt}, 1);
      syscall_en = 1'b0;

      // MTHI
      md_op = 4'd7; data_x = 32'h55;
      step();
      md_op = 4'd0;
      rd(4'd5, 32'h55);

      // Reset during DIV
      en = 1'b1; md_op = 4'd3; data_x = 32'd1000; data_y = 32'd3;
      step();
      md_op = 4'd0;
      for (int i = 0; i < 9; i++) step();
      rst_n = 1'b0;
      step();
      chk("rstmid_busy", {31'd0, busy}, 0);
      chk("rstmid_done", {31'd0, done}, 0);
      chk("rstmid_halt", {31'd0, halt}, 0);
      chk("rstmid_display", display, 0);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (done) n++;
      end
      chk("rstmid_no_done", n, 0);
      rd(4'd5, 32'h0);
      rd(4'd6, 32'h0);
      md_op = 4'd8; data_x = 32'hA5;
      step();
      md_op = 4'd0;
      rd(4'd6, 32'hA5);

      step();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/syn_ex_muldiv.md
Name: syn_ex_muldiv

Overview:
- Execute-stage multiply/divide and syscall unit for the pipelined core; sits beside the ALU and branch-target logic in EX.
- Adds iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers, MFHI/MFLO/MTHI/MTLO, and a pipeline stall output.
- Generalises the syscall path to parameterised service codes with a sticky halt.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.
SYS_HALT, 10, $v0 value that raises halt.
SYS_DISP, 34, $v0 value that latches $a0 into display.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  pipeline advance enable for the EX instruction
md_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, others NONE
data_x  input  DATA_W  rs operand (dividend / multiplicand / MTxx source)
data_y  input  DATA_W  rt operand (divisor / multiplier)
syscall_en  input  1  EX instruction is SYSCALL
data_v0  input  DATA_W  forwarded $v0
data_a0  input  DATA_W  forwarded $a0
md_res  output  DATA_W  MFHI/MFLO read data, else 0
stall  output  1  freeze upstream stages this cycle
busy  output  1  iterative operation in progress
done  output  1  one-cycle pulse on HI/LO update by MULT/DIV
display  output  DATA_W  last displayed value
halt  output  1  sticky halt

Behaviour:
- Reset (rst_n=0 at a rising edge): hi, lo, counter, busy, done, display, halt all 0. Reset wins over every other event, including mid-operation; the aborted result is discarded.
- FSM IDLE/RUN. IDLE->RUN when en=1, md_op in 1..4, busy=0: latch operands (signed ops take magnitudes and record result signs), counter=DATA_W-1, busy=1 from the next cycle.
- RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle. On the step with counter=0: write hi/lo (sign-corrected), done=1 for that next cycle, busy=0, return to IDLE.
- Latency: start at edge N; done=1 and new hi/lo visible after edge N+DATA_W. Back-to-back ops cost DATA_W+1 cycles each.
- stall = busy & (md_op != NONE) & en, combinational. A stalled op is not executed; it is retried while held.
- Non-md instructions never stall.
- MULT/MULTU: {hi,lo} = full 2*DATA_W product, signed or unsigned.
- DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with dividend's sign.
- Divide by zero: lo = all ones, hi = data_x; still takes the full DATA_W cycles.
- DIV of MIN by -1: lo = MIN, hi = 0.
- MFHI/MFLO while not busy: md_res = hi/lo combinationally (unaffected by en). md_res = 0 for other ops and while stalled.
- MTHI/MTLO: when en=1 and not busy, write data_x to hi/lo at the edge.
- Syscall: on en=1 & syscall_en=1:
  - data_v0==SYS_DISP: display<=data_a0.
  - data_v0==SYS_HALT: halt<=1.
  - Other codes: no effect.
- Syscall is independent of busy.
- halt stays 1 until reset. Further syscalls still update display.
- en=0: no new start, no MT write, no syscall effect; a RUN operation continues to completion regardless of en.

Test Plan:
- MULT x=0xFFFFFFFD (-3), y=5, en=1 -> busy 32 cycles, done pulse; then MFLO md_res=0xFFFFFFF1, MFHI md_res=0xFFFFFFFF. MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234, done after 32 cycles.
- Issue MFLO one cycle after MULT start -> stall=1 for 31 cycles, md_res=0. On the cycle busy falls, stall=0 and md_res shows the new lo.
- Assert rst_n=0 at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0, no done pulse. A subsequent MTLO 0xA5 then MFLO -> 0xA5.
- syscall_en with v0=34, a0=0xCAFE -> display=0xCAFE. v0=10 -> halt=1 and stays 1. v0=34 with en=0 -> display unchanged.
